// File: rtl/tv_recorder.sv
// Capture buffer: records {stim, resp} samples on a valid/ready handshake, then
// replays them as zero-padded vector words. Optional checker: TV_RECORDER_CHECK_EN.
module tv_recorder #(
    parameter int STIM_W = 2,
    parameter int RESP_W = 1,
    parameter int VEC_W  = 6,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              cap_valid,
    input  logic [STIM_W-1:0] cap_stim,
    input  logic [RESP_W-1:0] cap_resp,
    output logic              cap_ready,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [VEC_W-1:0]  rd_data,
    output logic [AW-1:0]     rd_index,
    output logic [AW:0]       count,
    output logic              done
`ifdef TV_RECORDER_CHECK_EN
    ,
    input  logic [RESP_W-1:0] cap_exp,
    output logic [AW:0]       err_count,
    output logic              err_flag
`endif
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DUMP} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t           state, state_nxt;
    logic [VEC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [AW:0]      count_nxt;
    logic             done_nxt;
    logic             wr_en;
    logic             clr;
    logic [VEC_W-1:0] wr_word;

    always_comb begin
        wr_word = '0;
        wr_word[STIM_W+RESP_W-1:0] = {cap_stim, cap_resp};
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        done_nxt   = 1'b0;
        wr_en      = 1'b0;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                    clr       = 1'b1;
                end
            end
            CAPTURE: begin
                // start wins over both a sample and stop in the same cycle
                if (start) begin
                    clr = 1'b1;
                end else if (cap_valid) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    count_nxt  = count + 1'b1;
                    if (count_nxt == FULL || stop)
                        state_nxt = DUMP;
                end else if (stop) begin
                    state_nxt = (count == '0) ? IDLE : DUMP;
                end
            end
            DUMP: begin
                if (rd_ready) begin
                    if ({1'b0, rd_ptr} == count - 1'b1) begin
                        state_nxt  = IDLE;
                        rd_ptr_nxt = '0;
                        done_nxt   = 1'b1;
                    end else begin
                        rd_ptr_nxt = rd_ptr + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clr) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            done   <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign cap_ready = (state == CAPTURE);
    assign rd_valid  = (state == DUMP);
    assign rd_index  = rd_ptr;
    // outside DUMP the read port shows zero rather than stale storage
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

`ifdef TV_RECORDER_CHECK_EN
    logic        mism;
    logic [AW:0] err_count_nxt;

    // case inequality so X/Z on the response is flagged in simulation
    assign mism = (cap_resp !== cap_exp);

    always_comb begin
        err_count_nxt = err_count;
        if (clr)
            err_count_nxt = '0;
        else if (wr_en && mism)
            err_count_nxt = err_count + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            err_flag  <= 1'b0;
        end else begin
            err_count <= err_count_nxt;
            if (clr)
                err_flag <= 1'b0;
            else if (state_nxt == DUMP && err_count_nxt != '0)
                err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/tv_recorder.md
# tv_recorder

Synthesizable capture buffer that records stimulus/response pairs from a gate-level DUT and plays them back as packed test-vector words in the same bit layout the team's vector benches load from `.mem` files. It sits beside a DUT such as the implication cell, samples `{stimulus, response}` on a valid/ready handshake, and then streams the stored words out on a second valid/ready port for dumping or comparison. It is the writer of the vector format that the benches read.

## Interface
- `STIM_W`, default 2: stimulus bits per vector (a, b).
- `RESP_W`, default 1: response bits per vector.
- `VEC_W`, default 6: packed word width; must satisfy `VEC_W >= STIM_W+RESP_W`.
- `DEPTH`, default 4: number of stored vectors; must be ≥ 2. `AW = $clog2(DEPTH)`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse: clear the buffer and enter capture.
- `stop`  in  1  end capture early.
- `cap_valid`  in  1  capture sample is present.
- `cap_stim`  in  STIM_W  DUT stimulus.
- `cap_resp`  in  RESP_W  DUT response.
- `cap_ready`  out  1  recorder is accepting samples.
- `rd_valid`  out  1  `rd_data` holds a stored word.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_data`  out  VEC_W  `{zero pad, stim, resp}`, with resp in the LSBs.
- `rd_index`  out  AW  index of the word on `rd_data`.
- `count`  out  AW+1  number of stored vectors.
- `done`  out  1  one-cycle pulse after the last word is read.

## Operation
- FSM states: IDLE, CAPTURE, DUMP.
- IDLE:
  - `cap_ready=0`, `rd_valid=0`.
  - `start` moves to CAPTURE with `count`, `wr_ptr` and `rd_ptr` set to 0.
- CAPTURE:
  - `cap_ready=1`.
  - On `cap_valid`: write `{stim,resp}` to `mem[wr_ptr]`, then increment `wr_ptr` and `count`.
  - When the accepted sample makes `count==DEPTH`, go to DUMP.
- `stop` in CAPTURE:
  - With `count>0` (including a sample accepted in the same cycle): go to DUMP.
  - With `count==0` and no sample: go to IDLE; `done` is not pulsed.
- DUMP:
  - `rd_valid=1`, `rd_data=mem[rd_ptr]`, `rd_index=rd_ptr`.
  - On `rd_ready`, increment `rd_ptr`.
  - Accepting the word at `rd_ptr==count-1` returns to IDLE and pulses `done` in the following cycle.
- Simultaneous events:
  - `start` in CAPTURE restarts (count cleared); a `cap_valid` in the same cycle is dropped.
  - `start` beats `stop`.
  - `start` in DUMP is ignored.
- Storage is not cleared on `start`; only words below `count` are ever presented.
- Packing: upper `VEC_W-STIM_W-RESP_W` bits are 0, then `cap_stim` (MSB first), then `cap_resp`.

## Timing
- All outputs are registered state, or a mux of registered state (`rd_data`).
- Reset values: state IDLE; `cap_ready=0`, `rd_valid=0`, `rd_data=0`, `rd_index=0`, `count=0`, `done=0`; all mem entries 0.
- A reset assertion mid-capture or mid-dump returns to IDLE immediately (asynchronous); no `done` pulse.
- A capture accepted at edge N is visible in `count` after edge N.
- After the DEPTH-th accept at edge N, `rd_valid=1` with index 0 in cycle N+1 (one-cycle latency); `cap_ready` is 0 from N+1.
- While `rd_valid && !rd_ready`, `rd_data` and `rd_index` are held stable.
- Dump throughput is one word per cycle with `rd_ready` held high.
- `done` is high for exactly one cycle, the cycle after the final read handshake.

## Configuration
- Macro: `TV_RECORDER_CHECK_EN`.
- Defined:
  - Adds input `cap_exp[RESP_W]` and output `err_count[AW+1]` (reset 0, cleared on `start`).
  - Each accepted sample with `cap_resp !== cap_exp` increments `err_count`; in simulation, X or Z on the response counts as a mismatch.
  - Adds output `err_flag` (reset 0), set in DUMP when `err_count!=0`.
- Not defined: none of these ports or registers exist; behaviour is otherwise identical.

## Test plan
- Reset, `start`, then 4 samples a,b = 00, 01, 10, 11 with the implication response (1,1,0,1), `rd_ready=1` → `rd_data` = 6'b000001, 000011, 000100, 000111; `done` one cycle after the 4th read.
- `start`, 2 samples, then `stop` → `count=2`; exactly 2 words dumped, then IDLE.
- In DUMP, toggle `rd_ready` 0/1 each cycle → each word is held while `rd_ready=0` and no word is skipped or repeated; `rd_index` runs 0..3.
- `start` with `cap_valid` in the same cycle in CAPTURE → sample dropped, `count=0`. `stop` with `count==0` → IDLE, no `done`.
- Assert `rst_n` low mid-dump → outputs go to their reset values immediately; a following `start` captures cleanly.
- With `TV_RECORDER_CHECK_EN` defined, feed one wrong response out of 4 → `err_count=1` and `err_flag=1` in DUMP.
